// File: rtl/req_encoder.sv
// Purpose : sticky 4-line request collector that presents one encoded index at a time.
// Latency : request sampled at edge k is pending after k and presented after k+1 when idle.
// Backpressure: ready=0 holds {S1,S0}/valid stable while new requests keep accumulating.
//
// Ports:
//   clk               rising-edge clock for all state
//   rst               asynchronous active-high reset
//   R0..R3            level-sampled request lines, OR'd into the pending register each edge
//   ready             consumer accepts the presented index when valid=1 and ready=1
//   S0, S1            registered encoded index {S1,S0} of the presented request
//   valid             registered; {S1,S0} holds a grant awaiting acceptance
//   pend_cnt          registered popcount of the pending register (0..4)
//
// Parameter RR_EN: 1 = round-robin search from a rotating pointer,
//                  0 = fixed priority, R0 highest.

module req_encoder #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       R0,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    input  logic       ready,
    output logic       S0,
    output logic       S1,
    output logic       valid,
    output logic [2:0] pend_cnt
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] pending;
    logic [1:0] ptr;
    logic [1:0] code;

    logic [3:0] req_vec;
    logic       accept;
    logic [3:0] served;
    logic [3:0] pend_upd;
    logic [1:0] ptr_upd;
    logic [3:0] sel_src;
    logic [1:0] sel_base;
    logic [1:0] sel_idx;

    // First set bit of p, searching upward from base with wrap 3->0.
    // With base=0 this degenerates to lowest-index-first priority.
    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && p[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [2:0] popcount(input logic [3:0] p);
        popcount = {2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]};
    endfunction

    always_comb begin
        req_vec = {R3, R2, R1, R0};

        // ready only matters while something is presented
        accept  = valid & ready;
        served  = accept ? (4'b0001 << code) : 4'b0000;

        // Clear first, then OR in new requests: a request on the accepting
        // edge for the same index keeps that bit set.
        pend_upd = (pending & ~served) | req_vec;

        ptr_upd  = (accept && (RR_EN != 0)) ? code + 2'd1 : ptr;

        // From IDLE the grant comes from the already-registered pending value
        // (this is what gives the 2-cycle request-to-valid latency). On an
        // accept the next grant is chosen from the post-clear value so grants
        // run back-to-back with the freshly advanced pointer.
        if (state == ST_IDLE) begin
            sel_src  = pending;
            sel_base = (RR_EN != 0) ? ptr : 2'd0;
        end else begin
            sel_src  = pend_upd;
            sel_base = (RR_EN != 0) ? ptr_upd : 2'd0;
        end
        sel_idx = pick(sel_src, sel_base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 4'b0000;
            ptr      <= 2'd0;
            code     <= 2'd0;
            valid    <= 1'b0;
            pend_cnt <= 3'd0;
        end else begin
            pending  <= pend_upd;
            pend_cnt <= popcount(pend_upd);
            ptr      <= ptr_upd;

            case (state)
                ST_IDLE: begin
                    if (pending != 4'b0000) begin
                        code  <= sel_idx;
                        valid <= 1'b1;
                        state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Without ready the code is frozen; late requests only
                    // land in pending and are considered at the next load.
                    if (ready) begin
                        if (pend_upd != 4'b0000) begin
                            code  <= sel_idx;
                            valid <= 1'b1;
                        end else begin
                            valid <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign S0 = code[0];
    assign S1 = code[1];

endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin selection among pending requests, 0 = fixed priority with R0 highest and R3 lowest.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port R0  input  1  request line 0, level-sampled each clk edge.
REQ-005 Port R1  input  1  request line 1, level-sampled each clk edge.
REQ-006 Port R2  input  1  request line 2, level-sampled each clk edge.
REQ-007 Port R3  input  1  request line 3, level-sampled each clk edge.
REQ-008 Port ready  input  1  consumer accepts the presented code when ready=1 and valid=1.
REQ-009 Port S0  output  1  LSB of the encoded index of the presented request (registered).
REQ-010 Port S1  output  1  MSB of the encoded index of the presented request (registered).
REQ-011 Port valid  output  1  {S1,S0} holds a granted request awaiting acceptance (registered).
REQ-012 Port pend_cnt  output  3  popcount of the pending register, range 0..4 (registered).

Function
REQ-013 The block SHALL keep a 4-bit pending register; each edge it SHALL OR in {R3,R2,R1,R0}, so requests are sticky until served.
REQ-014 The block SHALL clear pending bit i only on an accepting edge (valid=1, ready=1, {S1,S0}=i).
REQ-015 If R_i=1 on the same edge that accepts index i, pending bit i SHALL remain 1 (set wins over clear).
REQ-016 The FSM SHALL have two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-017 In IDLE with pending!=0, the next edge SHALL load {S1,S0} with the selected index, set valid=1, and enter PRESENT.
REQ-018 In IDLE with pending=0, the block SHALL remain in IDLE with valid=0.
REQ-019 A request asserted at edge k SHALL be in pending after edge k, with valid=1 after edge k+1 (2-cycle latency from IDLE).
REQ-020 In PRESENT with ready=0, {S1,S0} and valid SHALL hold stable. Pending bits SHALL still accumulate.
REQ-021 In PRESENT with ready=1, the accepting edge SHALL clear the served bit (per REQ-015) and evaluate the updated pending value.
REQ-022 If that updated value is nonzero, the same edge SHALL load the next selected index and keep valid=1, giving back-to-back grants with no bubble.
REQ-023 If that updated value is zero, the same edge SHALL deassert valid and return to IDLE.
REQ-024 With RR_EN=1, the block SHALL keep a 2-bit pointer, initially 0, set to (granted index + 1) mod 4 on each accept.
REQ-025 With RR_EN=1, selection SHALL search pending upward from the pointer with wrap-around 3->0.
REQ-026 With RR_EN=0, selection SHALL pick the lowest set pending index, and the pointer is unused.
REQ-027 Selection SHALL be performed only when loading {S1,S0}. A request arriving during PRESENT SHALL NOT change the presented code.
REQ-028 pend_cnt SHALL equal the popcount of the pending register after the same edge, 3-bit unsigned; value 4 is legal and SHALL NOT wrap.
REQ-029 ready while valid=0 SHALL have no effect.

Reset
REQ-030 While rst=1, outputs SHALL be S0=0, S1=0, valid=0 and pend_cnt=0, with pending=0, pointer=0 and state IDLE, independent of clk.
REQ-031 Assertion of rst mid-operation (PRESENT, any pending) SHALL immediately discard all pending requests and the presented code.
REQ-032 Request lines sampled on the first clk edge after rst deasserts SHALL be captured normally.

Verification
REQ-033 Single request: R2=1 for one cycle from IDLE -> pend_cnt=1, then next cycle valid=1, S1S0=10; ready=1 -> valid=0, pend_cnt=0.
REQ-034 Round-robin (RR_EN=1): R0..R3 all pulsed together, ready held 1 -> grants 00,01,10,11 on consecutive cycles, no bubble, then valid=0; pend_cnt 4,3,2,1,0.
REQ-035 Fixed priority (RR_EN=0): R3 and R1 pending, then R0 pulsed while 01 is presented with ready=0 -> 01 held stable; after accept, 00 is granted, then 11.
REQ-036 Set-wins: R1 held high continuously with ready=1 -> index 01 re-granted every cycle, pend_cnt stays at or above 1, valid never drops.
REQ-037 Backpressure: valid=1, ready=0 for 10 cycles while R0..R3 toggle -> S1S0 constant; pend_cnt reaches 4 and does not exceed it.
REQ-038 Reset mid-operation: rst pulsed asynchronously between edges while in PRESENT with pend_cnt=3 -> valid=0, S1S0=00, pend_cnt=0 immediately; the first post-reset grant starts the search at pointer 0.
